trace_dump_apb_master: RTL and testbench
========================================

Name: trace_dump_apb_master

Overview:
- APB initiator that drains the CPU branch-trace buffer through that buffer's APB responder port.
- Reads the trace status and write pointer, then reads every valid entry oldest-first, two APB reads per entry.
- Presents each entry as a valid/ready stream of {repeat count, from-PC, to-PC} to a debug UART or DMA packetiser.
- Sits in the debug subsystem next to the trace buffer and shares its APB segment.

Parameters:
- TRACE_WORDS, 1024: depth of the target trace buffer; TW = $clog2(TRACE_WORDS).
- BASE_ADDR, 32'h0000_0000: APB base of the trace buffer.
- TIMEOUT_CYCLES, 64: maximum ACCESS-phase cycles waiting for pready_i before the transfer is aborted.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; begins a dump, ignored unless idle
- busy_o  out  1  dump in progress
- done_o  out  1  one-cycle pulse at dump end (normal or error)
- err_o  out  1  sticky error; cleared by the next accepted start_i
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- paddr_o  out  32  APB address
- pwrite_o  out  1  always 0
- pwdata_o  out  48  always 0
- prdata_i  in  48  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB error
- ent_valid_o  out  1  entry valid
- ent_ready_i  in  1  entry accepted
- ent_idx_o  out  TW  buffer index of the entry
- ent_from_o  out  32  branch source PC
- ent_to_o  out  32  branch target PC
- ent_cnt_o  out  16  repeat count

Behaviour:
- Reset values: all outputs 0; state IDLE.
- APB timing per read:
  - SETUP is 1 cycle: psel=1, penable=0, paddr valid.
  - ACCESS follows: psel=1, penable=1, held until pready_i=1.
  - prdata_i and pslverr_i are sampled on the pready_i cycle.
  - psel/penable drop the next cycle; there are no back-to-back transfers, so at least 1 idle cycle separates reads.
- Address map (byte offsets from BASE_ADDR):
  - Registers: offset | 0x1_0000. STATUS at +0xC: bits[2:0] trace state, bit3 wrapped. WPTR at +0x10: bits[TW-1:0] = next write index.
  - RAM word for entry n:
    - LO at n*8: bits[31:0] = from_pc, bits[47:32] = cnt.
    - HI at n*8+4: bits[31:0] = to_pc.
- State machine:
  - IDLE: on start_i, clear err_o, set busy_o, go to RD_STAT.
  - RD_STAT: read STATUS; latch wrapped = bit3. Go to RD_PTR.
  - RD_PTR: read WPTR; latch ptr[TW-1:0].
    - If wrapped: remaining = TRACE_WORDS, idx = ptr.
    - Else: remaining = ptr, idx = 0.
    - If remaining == 0, go to FIN; else go to RD_LO.
  - RD_LO: read entry idx LO; latch from and cnt. Go to RD_HI.
  - RD_HI: read entry idx HI; latch to. Go to EMIT.
  - EMIT: ent_valid_o=1 and the payload is held stable until ent_ready_i.
    - On handshake: idx = (idx+1) mod 2^TW (wraps TRACE_WORDS-1 -> 0) and remaining -= 1.
    - If remaining then reaches 0, go to FIN; else go to RD_LO in the next cycle.
  - FIN: done_o=1 for 1 cycle, busy_o=0, return to IDLE.
- Errors:
  - pslverr_i=1 on any read: set err_o, discard that read's data, emit no partial entry, go to FIN.
  - Timeout: the ACCESS counter reaches TIMEOUT_CYCLES without pready_i. Then set err_o, drop psel/penable, go to FIN.
- remaining is TW+1 bits wide so that TRACE_WORDS is representable.
- start_i while busy is ignored. An entry already valid is never dropped or altered by anything except rst_i.
- rst_i mid-dump: everything returns to reset values next edge, including a mid-ACCESS APB phase (psel drops immediately). No done_o pulse is generated.
- Minimum per-entry latency with ent_ready_i held 1 and pready_i on the first ACCESS cycle: 2×(setup+access+gap) + 1 = 7 cycles.

Test Plan:
- Responder model: STATUS wrapped=0, WPTR=0; start_i -> 2 register reads, 0 entries, done_o after the last read, err_o=0.
- WPTR=3, not wrapped; RAM[0..2] = {cnt=5, 0x100 -> 0x200}, {0, 0x204 -> 0x300}, {0xFFFF, 0x304 -> 0x100} -> 3 entries, idx 0,1,2, exact values. paddr sequence: +0x1000C, +0x10010, +0x0, +0x4, +0x8, +0xC, +0x10, +0x14.
- TRACE_WORDS=8, wrapped=1, WPTR=5 -> 8 entries with idx 5,6,7,0,1,2,3,4, then done_o.
- ent_ready_i low for 10 cycles on the 2nd entry -> payload stable, no APB activity while stalled, no loss or duplication. pready_i delayed by 2 cycles -> penable held throughout.
- pslverr_i on entry-1 HI read -> entry 0 emitted, entry 1 not emitted, err_o=1, done_o pulse. Next start_i clears err_o.
- pready_i never asserted -> abort after 64 ACCESS cycles with err_o=1. Separately, rst_i during RD_HI ACCESS -> psel_o=0 next cycle, all outputs 0.

Source files
------------

// File: rtl/trace_dump_apb_master.sv
// Drains a branch-trace buffer over APB oldest-first into a valid/ready entry stream.
// Each entry takes two 3-cycle reads plus one emit cycle; a stalled entry holds the bus idle.
module trace_dump_apb_master #(
   parameter int          TRACE_WORDS    = 1024,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 64,
   localparam int         TW             = $clog2(TRACE_WORDS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic          psel_o,
   output logic          penable_o,
   output logic [31:0]   paddr_o,
   output logic          pwrite_o,
   output logic [47:0]   pwdata_o,
   input  logic [47:0]   prdata_i,
   input  logic          pready_i,
   input  logic          pslverr_i,
   output logic          ent_valid_o,
   input  logic          ent_ready_i,
   output logic [TW-1:0] ent_idx_o,
   output logic [31:0]   ent_from_o,
   output logic [31:0]   ent_to_o,
   output logic [15:0]   ent_cnt_o
);

   localparam int          RW        = TW + 1;
   localparam int          CW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h0001_000C;
   localparam logic [31:0] WPTR_ADDR = BASE_ADDR + 32'h0001_0010;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_STAT,
      S_RD_PTR,
      S_RD_LO,
      S_RD_HI,
      S_EMIT,
      S_FIN
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_ACCESS,
      PH_GAP
   } phase_t;

   typedef struct packed {
      logic [15:0] cnt;
      logic [31:0] from_pc;
      logic [31:0] to_pc;
   } ent_t;

   state_t        state;
   state_t        state_nxt;
   phase_t        phase;
   phase_t        phase_nxt;
   logic [CW-1:0] tcnt;
   logic          wrapped;
   logic [TW-1:0] idx;
   logic [RW-1:0] remaining;
   ent_t          ent;
   logic          err;

   logic          in_read;
   logic          access;
   logic          xfer_ok;
   logic          xfer_err;
   logic          tout;
   logic          emit_hs;
   logic [31:0]   ent_addr;

   assign in_read  = (state == S_RD_STAT) || (state == S_RD_PTR) ||
                     (state == S_RD_LO)   || (state == S_RD_HI);
   assign access   = in_read && (phase == PH_ACCESS);
   assign xfer_ok  = access && pready_i && !pslverr_i;
   assign xfer_err = access && pready_i && pslverr_i;
   assign tout     = access && !pready_i && (tcnt == CW'(TIMEOUT_CYCLES - 1));
   assign emit_hs  = (state == S_EMIT) && ent_ready_i;
   assign ent_addr = BASE_ADDR + 32'({idx, 3'b000});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         phase <= PH_SETUP;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   // The gap cycle after each completed read is where the next read is chosen.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_nxt = S_RD_STAT;
               phase_nxt = PH_SETUP;
            end
         end
         S_RD_STAT, S_RD_PTR, S_RD_LO, S_RD_HI: begin
            case (phase)
               PH_SETUP: phase_nxt = PH_ACCESS;
               PH_ACCESS: begin
                  if (xfer_ok) begin
                     phase_nxt = PH_GAP;
                  end else if (xfer_err || tout) begin
                     state_nxt = S_FIN;
                     phase_nxt = PH_SETUP;
                  end
               end
               default: begin
                  phase_nxt = PH_SETUP;
                  case (state)
                     S_RD_STAT: state_nxt = S_RD_PTR;
                     S_RD_PTR:  state_nxt = (remaining == '0) ? S_FIN : S_RD_LO;
                     S_RD_LO:   state_nxt = S_RD_HI;
                     default:   state_nxt = S_EMIT;
                  endcase
               end
            endcase
         end
         S_EMIT: begin
            if (ent_ready_i) begin
               phase_nxt = PH_SETUP;
               state_nxt = (remaining == RW'(1)) ? S_FIN : S_RD_LO;
            end
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tcnt      <= '0;
         wrapped   <= 1'b0;
         idx       <= '0;
         remaining <= '0;
         ent       <= '0;
         err       <= 1'b0;
      end else begin
         if (access && !pready_i) begin
            tcnt <= tcnt + CW'(1);
         end else begin
            tcnt <= '0;
         end

         if ((state == S_IDLE) && start_i) begin
            err <= 1'b0;
         end else if (xfer_err || tout) begin
            err <= 1'b1;
         end

         // Read data is only taken on a clean completion; errored data never reaches the entry.
         if (xfer_ok) begin
            case (state)
               S_RD_STAT: wrapped <= prdata_i[3];
               S_RD_PTR: begin
                  if (wrapped) begin
                     remaining <= RW'(TRACE_WORDS);
                     idx       <= prdata_i[TW-1:0];
                  end else begin
                     remaining <= {1'b0, prdata_i[TW-1:0]};
                     idx       <= '0;
                  end
               end
               S_RD_LO: begin
                  ent.cnt     <= prdata_i[47:32];
                  ent.from_pc <= prdata_i[31:0];
               end
               S_RD_HI: ent.to_pc <= prdata_i[31:0];
               default: ;
            endcase
         end

         if (emit_hs) begin
            idx       <= idx + TW'(1);
            remaining <= remaining - RW'(1);
         end
      end
   end

   always_comb begin
      paddr_o = '0;
      if (psel_o) begin
         case (state)
            S_RD_STAT: paddr_o = STAT_ADDR;
            S_RD_PTR:  paddr_o = WPTR_ADDR;
            S_RD_LO:   paddr_o = ent_addr;
            S_RD_HI:   paddr_o = ent_addr + 32'h4;
            default:   paddr_o = '0;
         endcase
      end
   end

   assign psel_o      = in_read && (phase != PH_GAP);
   assign penable_o   = access;
   assign pwrite_o    = 1'b0;
   assign pwdata_o    = '0;
   assign busy_o      = (state != S_IDLE) && (state != S_FIN);
   assign done_o      = (state == S_FIN);
   assign err_o       = err;
   assign ent_valid_o = (state == S_EMIT);
   assign ent_idx_o   = idx;
   assign ent_from_o  = ent.from_pc;
   assign ent_to_o    = ent.to_pc;
   assign ent_cnt_o   = ent.cnt;

endmodule

// File: tb/tb_trace_dump_apb_master.sv
// Bench for trace_dump_apb_master: APB responder model plus address and entry scoreboards.
module tb_trace_dump_apb_master;

   localparam int          TRACE_WORDS = 8;
   localparam int          TW          = 3;
   localparam logic [31:0] BASE        = 32'h2000_0000;
   localparam int          TIMEOUT     = 64;

   typedef struct packed {
      logic [TW-1:0] idx;
      logic [31:0]   from_pc;
      logic [31:0]   to_pc;
      logic [15:0]   cnt;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst, start, pready, pslverr, ent_ready;
   logic [47:0]   prdata;
   logic          busy, done, err, psel, penable, pwrite, ent_valid;
   logic [31:0]   paddr, ent_from, ent_to;
   logic [47:0]   pwdata;
   logic [TW-1:0] ent_idx;
   logic [15:0]   ent_cnt;

   int            n_vec = 0;
   int            n_err = 0;
   logic [31:0]   exp_addr[$];
   ent_t          exp_ent[$];
   logic [47:0]   ram_lo[TRACE_WORDS];
   logic [47:0]   ram_hi[TRACE_WORDS];
   logic          wrapped_m = 1'b0;
   logic [TW-1:0] wptr_m = '0;
   int            dly = 0;
   logic          hang = 1'b0;
   logic          err_en = 1'b0;
   logic [31:0]   err_addr = '0;
   logic          lat_en = 1'b0;
   int            hs_cnt = 0;
   int            done_cnt = 0;
   int            cyc = 0;

   always #5 clk = ~clk;

   trace_dump_apb_master #(
      .TRACE_WORDS(TRACE_WORDS), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
      .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr),
      .ent_valid_o(ent_valid), .ent_ready_i(ent_ready), .ent_idx_o(ent_idx),
      .ent_from_o(ent_from), .ent_to_o(ent_to), .ent_cnt_o(ent_cnt)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Upper bits of the register reads are all ones so any failure to mask them shows up.
   function automatic logic [47:0] rd_model(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off == 32'h0001_000C) return {{44{1'b1}}, wrapped_m, 3'b110};
      if (off == 32'h0001_0010) return {{(48 - TW){1'b1}}, wptr_m};
      if (off < 32'(TRACE_WORDS * 8) && off[1:0] == 2'b00)
         return off[2] ? ram_hi[off[5:3]] : ram_lo[off[5:3]];
      return 48'hDEAD_DEAD_DEAD;
   endfunction

   // Responder: answers after dly waiting ACCESS cycles, never while hang is set.
   initial begin
      int acc_cnt;
      acc_cnt = 0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (psel && penable && !rst) begin
            if (!hang && acc_cnt >= dly) begin
               pready  = 1'b1;
               prdata  = rd_model(paddr);
               pslverr = err_en && (paddr == err_addr);
               acc_cnt = 0;
            end else begin
               pready  = 1'b0;
               pslverr = 1'b0;
               prdata  = 48'({$urandom(), $urandom()});
               acc_cnt++;
            end
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            acc_cnt = 0;
         end
      end
   end

   logic        prev_wait = 1'b0;
   logic [31:0] prev_addr = '0;
   int          acc_run = 0;
   logic        prev_stall = 1'b0;
   ent_t        prev_ent = '0;
   ent_t        cur;
   int          prev_hs = 0;
   logic        have_hs = 1'b0;

   always @(negedge clk) begin
      cyc++;
      cur = {ent_idx, ent_from, ent_to, ent_cnt};
      if (prev_wait && !rst && acc_run < TIMEOUT)
         chk("penable_held", {psel, penable, paddr}, {2'b11, prev_addr});
      if (psel && !penable && !rst) begin
         chk("apb_write_fields", {pwrite, pwdata}, 0);
         if (exp_addr.size() == 0) chk("apb_extra_read", 1, 0);
         else chk("paddr", paddr, exp_addr.pop_front());
      end
      if (ent_valid && !rst) chk("apb_idle_in_emit", psel, 0);
      if (prev_stall && !rst) chk("ent_hold", {ent_valid, cur}, {1'b1, prev_ent});
      if (ent_valid && ent_ready && !rst) begin
         hs_cnt++;
         if (exp_ent.size() == 0) chk("ent_extra", 1, 0);
         else chk("ent", cur, exp_ent.pop_front());
         if (lat_en && have_hs) chk("ent_latency", cyc - prev_hs, 7);
         prev_hs = cyc;
         have_hs = 1'b1;
      end
      if (!busy) have_hs = 1'b0;
      if (done && !rst) done_cnt++;
      acc_run    = (psel && penable) ? acc_run + 1 : 0;
      prev_wait  = psel && penable && !pready;
      prev_addr  = paddr;
      prev_stall = ent_valid && !ent_ready;
      prev_ent   = cur;
   end

   // Expected read addresses and entries for one dump against the current responder contents.
   task automatic push_dump();
      int          rem, i0, i;
      logic [31:0] a;
      ent_t        e;
      exp_addr.push_back(BASE + 32'h0001_000C);
      if (hang) return;
      exp_addr.push_back(BASE + 32'h0001_0010);
      rem = wrapped_m ? TRACE_WORDS : int'(wptr_m);
      i0  = wrapped_m ? int'(wptr_m) : 0;
      for (int k = 0; k < rem; k++) begin
         i = (i0 + k) % TRACE_WORDS;
         a = BASE + 32'(i * 8);
         exp_addr.push_back(a);
         if (err_en && err_addr == a) return;
         exp_addr.push_back(a + 32'h4);
         if (err_en && err_addr == a + 32'h4) return;
         e = {TW'(i), ram_lo[i][31:0], ram_hi[i][31:0], ram_lo[i][47:32]};
         exp_ent.push_back(e);
      end
   endtask

   task automatic drv_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done_seen"}, done, 1);
   endtask

   task automatic end_dump(input string tag, input int d0, input logic exp_err);
      wait_done(tag, 600);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_addr_left"}, exp_addr.size(), 0);
      chk({tag, "_ent_left"}, exp_ent.size(), 0);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n, acc;
      rst = 1'b1; start = 1'b0; ent_ready = 1'b1;
      for (int i = 0; i < TRACE_WORDS; i++) begin
         ram_lo[i] = '0;
         ram_hi[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_apb", {psel, penable, paddr, pwrite, pwdata}, 0);
      chk("rst_ctrl", {busy, done, err, ent_valid}, 0);
      chk("rst_ent", {ent_idx, ent_from, ent_to, ent_cnt}, 0);
      rst = 1'b0;

      // Empty buffer: two register reads, no entries.
      wrapped_m = 1'b0; wptr_m = 3'd0;
      d0 = done_cnt; push_dump(); drv_start(); end_dump("empty", d0, 1'b0);

      // Three entries, not wrapped, with minimum-latency checking.
      ram_lo[0] = {16'd5, 32'h100};      ram_hi[0] = {16'hABCD, 32'h200};
      ram_lo[1] = {16'd0, 32'h204};      ram_hi[1] = {16'h1234, 32'h300};
      ram_lo[2] = {16'hFFFF, 32'h304};   ram_hi[2] = {16'hFFFF, 32'h100};
      wptr_m = 3'd3; lat_en = 1'b1;
      d0 = done_cnt; push_dump(); drv_start(); end_dump("three", d0, 1'b0);
      lat_en = 1'b0;

      // Wrapped buffer: full depth starting at the write pointer.
      for (int i = 0; i < TRACE_WORDS; i++) begin
         ram_lo[i] = 48'({$urandom(), $urandom()});
         ram_hi[i] = 48'({$urandom(), $urandom()});
      end
      wrapped_m = 1'b1; wptr_m = 3'd5;
      d0 = done_cnt; push_dump(); drv_start(); end_dump("wrap", d0, 1'b0);

      // Slow responder plus a 10-cycle stall on the second entry.
      wrapped_m = 1'b0; wptr_m = 3'd3; dly = 2;
      d0 = done_cnt; push_dump(); drv_start();
      n = 0;
      while (hs_cnt == 0 + hs_cnt - (hs_cnt - 0) && n < 0) n++;
      begin
         int h0;
         h0 = hs_cnt - (3 - exp_ent.size());
         n = 0;
         while (hs_cnt < h0 + 1 && n < 300) begin @(negedge clk); n++; end
      end
      @(posedge clk); #1 ent_ready = 1'b0;
      n = 0;
      while (!ent_valid && n < 300) begin @(negedge clk); n++; end
      chk("stall_entry_valid", ent_valid, 1);
      repeat (10) @(negedge clk);
      chk("stall_still_valid", {ent_valid, ent_idx}, {1'b1, 3'd1});
      @(posedge clk); #1 ent_ready = 1'b1;
      end_dump("stall", d0, 1'b0);
      dly = 0;

      // Slave error on entry 1 HI read: entry 0 only.
      err_en = 1'b1; err_addr = BASE + 32'hC;
      d0 = done_cnt; push_dump(); drv_start(); end_dump("slverr", d0, 1'b1);
      err_en = 1'b0;

      // Next start clears the sticky error.
      wptr_m = 3'd0;
      d0 = done_cnt; push_dump(); drv_start();
      @(negedge clk);
      chk("err_cleared_on_start", {busy, err}, {1'b1, 1'b0});
      end_dump("clear", d0, 1'b0);

      // No pready at all: abort after TIMEOUT access cycles.
      hang = 1'b1;
      d0 = done_cnt; push_dump(); drv_start();
      acc = 0; n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
         if (psel && penable) acc++;
      end
      chk("timeout_access_cycles", acc, TIMEOUT);
      end_dump("timeout", d0, 1'b1);
      hang = 1'b0;

      // Reset in the middle of an entry HI access.
      wptr_m = 3'd3; dly = 5;
      exp_addr.push_back(BASE + 32'h0001_000C);
      exp_addr.push_back(BASE + 32'h0001_0010);
      exp_addr.push_back(BASE);
      exp_addr.push_back(BASE + 32'h4);
      d0 = done_cnt; drv_start();
      n = 0;
      while (!(penable && paddr == BASE + 32'h4) && n < 300) begin @(negedge clk); n++; end
      chk("hi_access_reached", {penable, paddr}, {1'b1, BASE + 32'h4});
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_apb", {psel, penable, paddr}, 0);
      chk("midrst_ctrl", {busy, done, err, ent_valid}, 0);
      chk("midrst_ent", {ent_idx, ent_from, ent_to, ent_cnt}, 0);
      @(negedge clk);
      rst = 1'b0; dly = 0;
      repeat (20) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_idle", {busy, psel}, 0);
      chk("midrst_addr_left", exp_addr.size(), 0);
      chk("midrst_ent_left", exp_ent.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
